// File: rtl/mem_arbiter.sv
// Two-port (fetch / data) arbiter in front of the SRAM controller: round-robin grant,
// request fields held stable per transaction, local error response for unmapped or hung accesses.
module mem_arbiter #(
  parameter logic [31:0] MEM_LIMIT      = 32'h0001_0000,
  parameter int          TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_data,
  output logic        if_valid,
  output logic        if_err,
  input  logic        d_req,
  input  logic        d_rw,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [1:0]  d_size,
  output logic [31:0] d_rdata,
  output logic        d_valid,
  output logic        d_err,
  output logic [31:0] mem_address,
  output logic        mem_rw_req,
  output logic        mem_rw,
  output logic [31:0] mem_write_data,
  output logic [1:0]  mem_size,
  input  logic [31:0] mem_read_data,
  input  logic        mem_data_valid
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_GAP} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          lastg_q, lastg_d;   // 1 = data port won the last grant
  logic          gnt_q, gnt_d;       // 1 = data port owns the current transaction
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic          rw_q, rw_d, rw_req_q, rw_req_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   if_data_q, if_data_d, d_rdata_q, d_rdata_d;
  logic          if_valid_q, if_valid_d, if_err_q, if_err_d;
  logic          d_valid_q, d_valid_d, d_err_q, d_err_d;
  logic          pick_data, resp_en, resp_err;
  logic [31:0]   resp_data;

  function automatic logic is_mapped(input logic [31:0] a);
    return !a[31] && (a < MEM_LIMIT);
  endfunction

  always_comb begin
    state_d    = state_q;
    tmo_d      = tmo_q;
    lastg_d    = lastg_q;
    gnt_d      = gnt_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    size_d     = size_q;
    wdata_d    = wdata_q;
    rw_req_d   = 1'b0;
    if_data_d  = if_data_q;
    d_rdata_d  = d_rdata_q;
    if_valid_d = 1'b0;
    if_err_d   = 1'b0;
    d_valid_d  = 1'b0;
    d_err_d    = 1'b0;
    resp_en    = 1'b0;
    resp_err   = 1'b0;
    resp_data  = '0;
    // Tie goes to whichever port did not win last time
    pick_data  = d_req & (~if_req | ~lastg_q);

    unique case (state_q)
      S_IDLE: begin
        if (if_req | d_req) begin
          gnt_d   = pick_data;
          lastg_d = pick_data;
          addr_d  = pick_data ? d_addr : if_addr;
          rw_d    = pick_data & d_rw;
          size_d  = pick_data ? ((d_size == 2'd3) ? 2'd2 : d_size) : 2'd2;
          wdata_d = pick_data ? d_wdata : '0;
          if (is_mapped(addr_d)) begin
            rw_req_d = 1'b1;
            state_d  = S_ISSUE;
          end else begin
            resp_en  = 1'b1;
            resp_err = 1'b1;
            state_d  = S_RESP;
          end
        end
      end
      S_ISSUE: begin
        tmo_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_data_valid) begin
          resp_en   = 1'b1;
          resp_data = rw_q ? 32'd0 : mem_read_data;
          state_d   = S_RESP;
        end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
          resp_en  = 1'b1;
          resp_err = 1'b1;
          state_d  = S_RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      S_RESP:  state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (resp_en) begin
      if (gnt_d) begin
        d_valid_d = 1'b1;
        d_err_d   = resp_err;
        d_rdata_d = resp_data;
      end else begin
        if_valid_d = 1'b1;
        if_err_d   = resp_err;
        if_data_d  = resp_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      tmo_q      <= '0;
      lastg_q    <= 1'b1;
      gnt_q      <= 1'b0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      size_q     <= '0;
      wdata_q    <= '0;
      rw_req_q   <= 1'b0;
      if_data_q  <= '0;
      d_rdata_q  <= '0;
      if_valid_q <= 1'b0;
      if_err_q   <= 1'b0;
      d_valid_q  <= 1'b0;
      d_err_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmo_q      <= tmo_d;
      lastg_q    <= lastg_d;
      gnt_q      <= gnt_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      size_q     <= size_d;
      wdata_q    <= wdata_d;
      rw_req_q   <= rw_req_d;
      if_data_q  <= if_data_d;
      d_rdata_q  <= d_rdata_d;
      if_valid_q <= if_valid_d;
      if_err_q   <= if_err_d;
      d_valid_q  <= d_valid_d;
      d_err_q    <= d_err_d;
    end
  end

  assign if_data        = if_data_q;
  assign if_valid       = if_valid_q;
  assign if_err         = if_err_q;
  assign d_rdata        = d_rdata_q;
  assign d_valid        = d_valid_q;
  assign d_err          = d_err_q;
  assign mem_address    = addr_q;
  assign mem_rw_req     = rw_req_q;
  assign mem_rw         = rw_q;
  assign mem_write_data = wdata_q;
  assign mem_size       = size_q;

endmodule
